alsu_cmd_driver: RTL and testbench

ALSU_CMD_DRIVER -- requirements
Module: alsu_cmd_driver

---
 rtl/alsu_cmd_driver.sv | 193 +++++++++++++++++++
 tb/tb_alsu_cmd_driver.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_cmd_driver.sv
// Command driver for an ALSU: latches one command, drives the ALSU pins for a
// programmable number of cycles, waits out the ALSU pipeline, then returns the
// captured result on a valid/ready response channel.
module alsu_cmd_driver #(
  // ALSU input-register-to-out delay in clock edges, legal range 1..7
  parameter int unsigned ALSU_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,

  // Command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opcode,
  input  logic signed [2:0] cmd_a,
  input  logic signed [2:0] cmd_b,
  input  logic              cmd_cin,
  input  logic              cmd_serial_in,
  input  logic              cmd_red_a,
  input  logic              cmd_red_b,
  input  logic              cmd_bypass_a,
  input  logic              cmd_bypass_b,
  input  logic              cmd_direction,
  input  logic [1:0]        cmd_reps,

  // ALSU pin drives
  output logic [2:0]        alsu_opcode,
  output logic [2:0]        alsu_A,
  output logic [2:0]        alsu_B,
  output logic              alsu_cin,
  output logic              alsu_serial_in,
  output logic              alsu_red_op_A,
  output logic              alsu_red_op_B,
  output logic              alsu_bypass_A,
  output logic              alsu_bypass_B,
  output logic              alsu_direction,

  // ALSU results
  input  logic signed [5:0] alsu_out,
  input  logic [15:0]       alsu_leds,

  // Response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic signed [5:0] rsp_out,
  output logic              rsp_invalid,
  output logic              rsp_leds_nz,

  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StWait,
    StResp
  } state_e;

  // Everything the ALSU pins carry, in pin order
  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic       serial_in;
    logic       red_a;
    logic       red_b;
    logic       bypass_a;
    logic       bypass_b;
    logic       direction;
  } cmd_t;

  // Wait counter counts down to zero, so it is loaded with one less than the latency
  localparam logic [2:0] WaitLoad = 3'(ALSU_LATENCY - 1);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  cmd_t              pins_q, pins_d;
  cmd_t              cmd_in;
  logic [1:0]        rep_cnt_q, rep_cnt_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic signed [5:0] rsp_out_q, rsp_out_d;
  logic              rsp_invalid_q, rsp_invalid_d;
  logic              rsp_leds_nz_q, rsp_leds_nz_d;
  logic              cmd_invalid;

  assign cmd_in = {cmd_opcode, cmd_a, cmd_b, cmd_cin, cmd_serial_in, cmd_red_a, cmd_red_b,
                   cmd_bypass_a, cmd_bypass_b, cmd_direction};

  // Invalid-operation flag of the latched command; bypass masks it
  always_comb begin
    cmd_invalid = !(cmd_q.bypass_a || cmd_q.bypass_b) &&
                  (((cmd_q.red_a || cmd_q.red_b) && (cmd_q.opcode[1] || cmd_q.opcode[2])) ||
                   (cmd_q.opcode[1] && cmd_q.opcode[2]));
  end

  // Next-state logic: accept, drive repetitions, latency wait, response hold
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    rep_cnt_d     = rep_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    rsp_out_d     = rsp_out_q;
    rsp_invalid_d = rsp_invalid_q;
    rsp_leds_nz_d = rsp_leds_nz_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cmd_d     = cmd_in;
          rep_cnt_d = cmd_reps;
          state_d   = StDrive;
        end
      end
      StDrive: begin
        if (rep_cnt_q == 2'd0) begin
          wait_cnt_d = WaitLoad;
          state_d    = StWait;
        end else begin
          rep_cnt_d = rep_cnt_q - 2'd1;
        end
      end
      StWait: begin
        if (wait_cnt_q == 3'd0) begin
          // alsu_out now reflects the last driven cycle; capture it bit-exact
          rsp_out_d     = alsu_out;
          rsp_invalid_d = cmd_invalid;
          rsp_leds_nz_d = |alsu_leds;
          state_d       = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_out_d     = '0;
          rsp_invalid_d = 1'b0;
          rsp_leds_nz_d = 1'b0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pins are registered and carry the command only while the next state is DRIVE,
  // so the ALSU sees zeros (and its out clears) in every other state
  always_comb begin
    pins_d = (state_d == StDrive) ? cmd_d : '0;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cmd_q         <= '0;
      pins_q        <= '0;
      rep_cnt_q     <= 2'd0;
      wait_cnt_q    <= 3'd0;
      rsp_out_q     <= '0;
      rsp_invalid_q <= 1'b0;
      rsp_leds_nz_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      pins_q        <= pins_d;
      rep_cnt_q     <= rep_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      rsp_out_q     <= rsp_out_d;
      rsp_invalid_q <= rsp_invalid_d;
      rsp_leds_nz_q <= rsp_leds_nz_d;
    end
  end

  assign cmd_ready      = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign rsp_valid      = (state_q == StResp);
  assign rsp_out        = rsp_out_q;
  assign rsp_invalid    = rsp_invalid_q;
  assign rsp_leds_nz    = rsp_leds_nz_q;

  assign alsu_opcode    = pins_q.opcode;
  assign alsu_A         = pins_q.a;
  assign alsu_B         = pins_q.b;
  assign alsu_cin       = pins_q.cin;
  assign alsu_serial_in = pins_q.serial_in;
  assign alsu_red_op_A  = pins_q.red_a;
  assign alsu_red_op_B  = pins_q.red_b;
  assign alsu_bypass_A  = pins_q.bypass_a;
  assign alsu_bypass_B  = pins_q.bypass_b;
  assign alsu_direction = pins_q.direction;

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Bench for alsu_cmd_driver: a small ALSU environment (input register + output
// register) answers the pin drives; results are checked against expected values
// computed from the operation rules.
module tb_alsu_cmd_driver;

  localparam int unsigned Lat = 2;

  typedef struct packed {
    logic [2:0]        op;
    logic signed [2:0] a;
    logic signed [2:0] b;
    logic              cin;
    logic              serial;
    logic              red_a;
    logic              red_b;
    logic              byp_a;
    logic              byp_b;
    logic              dir;
  } cmd_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_opcode = '0;
  logic signed [2:0] cmd_a = '0;
  logic signed [2:0] cmd_b = '0;
  logic              cmd_cin = 1'b0;
  logic              cmd_serial_in = 1'b0;
  logic              cmd_red_a = 1'b0;
  logic              cmd_red_b = 1'b0;
  logic              cmd_bypass_a = 1'b0;
  logic              cmd_bypass_b = 1'b0;
  logic              cmd_direction = 1'b0;
  logic [1:0]        cmd_reps = '0;
  logic [2:0]        alsu_opcode, alsu_A, alsu_B;
  logic              alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
  logic              alsu_bypass_A, alsu_bypass_B, alsu_direction;
  logic signed [5:0] alsu_out;
  logic [15:0]       alsu_leds;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic signed [5:0] rsp_out;
  logic              rsp_invalid, rsp_leds_nz, busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alsu_cmd_driver #(.ALSU_LATENCY(Lat)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_opcode     (cmd_opcode),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .cmd_cin        (cmd_cin),
    .cmd_serial_in  (cmd_serial_in),
    .cmd_red_a      (cmd_red_a),
    .cmd_red_b      (cmd_red_b),
    .cmd_bypass_a   (cmd_bypass_a),
    .cmd_bypass_b   (cmd_bypass_b),
    .cmd_direction  (cmd_direction),
    .cmd_reps       (cmd_reps),
    .alsu_opcode    (alsu_opcode),
    .alsu_A         (alsu_A),
    .alsu_B         (alsu_B),
    .alsu_cin       (alsu_cin),
    .alsu_serial_in (alsu_serial_in),
    .alsu_red_op_A  (alsu_red_op_A),
    .alsu_red_op_B  (alsu_red_op_B),
    .alsu_bypass_A  (alsu_bypass_A),
    .alsu_bypass_B  (alsu_bypass_B),
    .alsu_direction (alsu_direction),
    .alsu_out       (alsu_out),
    .alsu_leds      (alsu_leds),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_out        (rsp_out),
    .rsp_invalid    (rsp_invalid),
    .rsp_leds_nz    (rsp_leds_nz),
    .busy           (busy)
  );

  cmd_t pins_obs;
  assign pins_obs = {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_red_op_A,
                     alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction};

  function automatic logic raw_invalid(input cmd_t c);
    return ((c.red_a || c.red_b) && (c.op[1] || c.op[2])) || (c.op[1] && c.op[2]);
  endfunction

  function automatic logic signed [5:0] sext(input logic [2:0] v);
    return {{3{v[2]}}, v};
  endfunction

  // One ALSU evaluation given the previous out value
  function automatic logic signed [5:0] alsu_step(input cmd_t c, input logic signed [5:0] prev);
    if (c.byp_a) return sext(c.a);
    if (c.byp_b) return sext(c.b);
    if (raw_invalid(c)) return 6'sd0;
    case (c.op)
      3'd0: return c.red_a ? {5'd0, &c.a} : c.red_b ? {5'd0, &c.b} : sext(c.a & c.b);
      3'd1: return c.red_a ? {5'd0, ^c.a} : c.red_b ? {5'd0, ^c.b} : sext(c.a ^ c.b);
      3'd2: return 6'(int'(c.a) + int'(c.b) + int'(c.cin));
      3'd3: return 6'(int'(c.a) * int'(c.b));
      3'd4: return c.dir ? {prev[4:0], c.serial} : {c.serial, prev[5:1]};
      3'd5: return c.dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
      default: return 6'sd0;
    endcase
  endfunction

  // ALSU environment: input register then output register (two-edge latency)
  cmd_t alsu_in_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      alsu_in_q <= '0;
      alsu_out  <= '0;
      alsu_leds <= '0;
    end else begin
      alsu_in_q <= pins_obs;
      alsu_out  <= alsu_step(alsu_in_q, alsu_out);
      alsu_leds <= raw_invalid(alsu_in_q) ? 16'hA5A5 : 16'h0000;
    end
  end

  // Expected response: apply the operation reps+1 times to a cleared out
  task automatic ref_model(input cmd_t c, input logic [1:0] reps, output logic signed [5:0] out,
                           output logic inv, output logic nz);
    logic signed [5:0] acc;
    acc = 6'sd0;
    for (int i = 0; i <= int'(reps); i++) acc = alsu_step(c, acc);
    out = acc;
    inv = !(c.byp_a || c.byp_b) && raw_invalid(c);
    nz  = raw_invalid(c);
  endtask

  function automatic cmd_t mk(input logic [2:0] op, input logic signed [2:0] a,
                              input logic signed [2:0] b, input logic cin, input logic serial,
                              input logic red_a, input logic byp_a, input logic dir);
    cmd_t c;
    c = '0;
    c.op = op; c.a = a; c.b = b; c.cin = cin; c.serial = serial;
    c.red_a = red_a; c.byp_a = byp_a; c.dir = dir;
    return c;
  endfunction

  task automatic drive_fields(input cmd_t c, input logic [1:0] reps);
    cmd_opcode = c.op; cmd_a = c.a; cmd_b = c.b; cmd_cin = c.cin; cmd_serial_in = c.serial;
    cmd_red_a = c.red_a; cmd_red_b = c.red_b; cmd_bypass_a = c.byp_a; cmd_bypass_b = c.byp_b;
    cmd_direction = c.dir; cmd_reps = reps;
  endtask

  // Full transaction with pin, latency, response, stall and handshake checks
  task automatic run_cmd(input cmd_t c, input logic [1:0] reps, input int stall,
                         input bit hold_valid, input logic signed [5:0] exp_out,
                         input logic exp_inv, input logic exp_nz, input string name);
    int k;
    bit seen;
    cmd_t exp_pins;
    logic signed [5:0] h_out;
    logic h_inv, h_nz;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL %s idle_ready: got %b want 1", name, cmd_ready);
    end
    drive_fields(c, reps);
    cmd_valid = 1'b1;
    @(negedge clk);
    k = 1; seen = 0;
    while (!seen && k <= 40) begin
      cmd_valid = hold_valid;
      drive_fields(cmd_t'(16'($urandom)), 2'($urandom));
      if (rsp_valid === 1'b1) seen = 1;
      else begin
        exp_pins = (k <= int'(reps) + 1) ? c : '0;
        total++;
        if (pins_obs !== exp_pins || cmd_ready !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL %s pins_k%0d: got pins=%h ready=%b busy=%b want pins=%h ready=0 busy=1",
                   name, k, pins_obs, cmd_ready, busy, exp_pins);
        end
        @(negedge clk);
        k++;
      end
    end
    total++;
    if (!seen || (k - 1) != int'(reps) + 1 + int'(Lat)) begin
      bad++;
      $display("FAIL %s latency: got %0d edges (seen=%0b) want %0d", name, k - 1, seen,
               int'(reps) + 1 + int'(Lat));
    end
    if (!seen) begin
      cmd_valid = 1'b0;
      return;
    end
    total++;
    if (rsp_out !== exp_out || rsp_invalid !== exp_inv || rsp_leds_nz !== exp_nz) begin
      bad++;
      $display("FAIL %s rsp: got out=%b inv=%b nz=%b want out=%b inv=%b nz=%b", name, rsp_out,
               rsp_invalid, rsp_leds_nz, exp_out, exp_inv, exp_nz);
    end
    h_out = rsp_out; h_inv = rsp_invalid; h_nz = rsp_leds_nz;
    repeat (stall) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      cmd_valid = hold_valid;
      drive_fields(cmd_t'(16'($urandom)), 2'($urandom));
      total++;
      if (rsp_valid !== 1'b1 || rsp_out !== h_out || rsp_invalid !== h_inv ||
          rsp_leds_nz !== h_nz || cmd_ready !== 1'b0 || pins_obs !== '0) begin
        bad++;
        $display("FAIL %s stall: got valid=%b out=%b inv=%b nz=%b ready=%b pins=%h want 1 %b %b %b 0 0",
                 name, rsp_valid, rsp_out, rsp_invalid, rsp_leds_nz, cmd_ready, pins_obs,
                 h_out, h_inv, h_nz);
      end
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s handshake: got valid=%b ready=%b busy=%b want 0 1 0", name, rsp_valid,
               cmd_ready, busy);
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (pins_obs !== '0 || rsp_valid !== 1'b0 || rsp_out !== 6'sd0 || rsp_invalid !== 1'b0 ||
        rsp_leds_nz !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got pins=%h valid=%b out=%b inv=%b nz=%b busy=%b want all 0",
               pins_obs, rsp_valid, rsp_out, rsp_invalid, rsp_leds_nz, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_release: got ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_directed;
    run_cmd(mk(3'd2, 3'sd3, 3'sd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 2'd0, 0, 1'b0,
            6'sd6, 1'b0, 1'b0, "add");
    run_cmd(mk(3'd3, -3'sd3, 3'sd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 2'd0, 0, 1'b0,
            6'b110111, 1'b0, 1'b0, "mult");
    run_cmd(mk(3'd4, 3'sd0, 3'sd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 2'd3, 0, 1'b0,
            6'b001111, 1'b0, 1'b0, "shift_burst");
    run_cmd(mk(3'd6, 3'sd1, 3'sd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 2'd0, 0, 1'b0,
            6'sd0, 1'b1, 1'b1, "invalid_op");
    run_cmd(mk(3'd2, -3'sd2, 3'sd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 2'd0, 0, 1'b0,
            6'b111110, 1'b0, 1'b1, "bypass");
  endtask

  task automatic test_backpressure;
    run_cmd(mk(3'd2, 3'sd1, 3'sd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 2'd1, 5, 1'b1,
            6'sd2, 1'b0, 1'b0, "backpressure");
  endtask

  task automatic test_random;
    cmd_t c;
    logic [1:0] reps;
    logic signed [5:0] eo;
    logic ei, en;
    for (int n = 0; n < 24; n++) begin
      c = cmd_t'(16'($urandom));
      reps = 2'($urandom);
      ref_model(c, reps, eo, ei, en);
      run_cmd(c, reps, int'($urandom_range(0, 3)), 1'($urandom), eo, ei, en, "random");
    end
  endtask

  // Start a command, reset after kr cycles, then confirm it was abandoned
  task automatic reset_during(input int kr, input string name);
    cmd_t c;
    logic signed [5:0] eo;
    logic ei, en;
    bit leak;
    c = mk(3'd4, 3'sd0, 3'sd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive_fields(c, 2'd2);
    cmd_valid = 1'b1;
    repeat (kr) @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (pins_obs !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s async: got pins=%h busy=%b valid=%b want 0 0 0", name, pins_obs, busy,
               rsp_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready_after: got %b want 1", name, cmd_ready);
    end
    leak = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) leak = 1;
    end
    total++;
    if (leak) begin
      bad++; $display("FAIL %s abandoned: got stray response/busy want none", name);
    end
    ref_model(c, 2'd1, eo, ei, en);
    run_cmd(c, 2'd1, 1, 1'b0, eo, ei, en, "after_reset");
  endtask

  task automatic test_reset_mid;
    reset_during(2, "reset_drive");
    reset_during(5, "reset_wait");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
